// File: rtl/asc_scroll_buffer_pkg.sv
// Shared character constants and lane helpers for the ASCII display path.
package asc_disp_pkg;

  localparam int unsigned ASC_W = 8;

  typedef logic [ASC_W-1:0] asc_char_t;

  localparam asc_char_t ASC_SPACE = 8'h20;

  // LSB position of lane k in a packed window; lane 0 is the leftmost (most significant) byte.
  function automatic int unsigned lane_lsb(input int unsigned num_digits, input int unsigned k);
    return ASC_W * (num_digits - 1 - k);
  endfunction

endpackage

// File: rtl/asc_scroll_buffer_if.sv
// Character write handshake into the scroll buffer.
interface asc_scroll_buffer_if;
  import asc_disp_pkg::*;

  asc_char_t in_char;
  logic      in_valid;
  logic      in_ready;

  modport master (output in_char, output in_valid, input  in_ready);
  modport slave  (input  in_char, input  in_valid, output in_ready);

endinterface

// File: rtl/asc_scroll_buffer_tick_gen.sv
// Scroll prescaler: pulses tick once every TICK_DIV enabled cycles.
module asc_tick_gen #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count while enabled, hold while disabled, flush on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/asc_scroll_buffer.sv
// Message store and scroll engine feeding per-digit ASCII-to-7-segment decoders.
module asc_scroll_buffer
  import asc_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TICK_DIV   = 25000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  asc_scroll_buffer_if.slave            bus,
  input  logic                          clear,
  input  logic                          scroll_en,
  output logic [$clog2(DEPTH+1)-1:0]    msg_len,
  output logic [ASC_W*NUM_DIGITS-1:0]   digits
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LW-1:0]               len;
  logic [LW-1:0]               base;
  asc_char_t                   mem [DEPTH];
  logic                        step;
  logic                        accept;
  logic                        static_msg;
  int unsigned                 len_u;
  int unsigned                 base_u;
  int unsigned                 idx;
  asc_char_t                   lane;
  logic [ASC_W*NUM_DIGITS-1:0] window;

  assign len_u        = 32'(len);
  assign base_u       = 32'(base);
  assign static_msg   = (len_u <= NUM_DIGITS);
  assign bus.in_ready = (len_u < DEPTH) && !clear;
  assign accept       = bus.in_valid && bus.in_ready;
  assign msg_len      = len;

  asc_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (scroll_en),
    .clr   (clear),
    .tick  (step)
  );

  // Length and scroll position; base uses the pre-write length so a message
  // growing past the display starts scrolling from base 0 on the following tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len  <= '0;
      base <= '0;
    end else if (clear) begin
      len  <= '0;
      base <= '0;
    end else begin
      if (accept) begin
        len <= LW'(len_u + 1);
      end
      if (static_msg) begin
        base <= '0;
      end else if (step) begin
        base <= (base == len) ? '0 : LW'(base_u + 1);
      end
    end
  end

  // Message storage; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[IW'(len_u)] <= bus.in_char;
    end
  end

  // Window over the virtual sequence mem[0..len-1] + space; base <= len and
  // k < NUM_DIGITS < period, so one conditional subtract wraps the index.
  always_comb begin
    window = '0;
    idx    = 0;
    lane   = ASC_SPACE;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      idx = base_u + k;
      if (idx >= len_u + 1) begin
        idx = idx - (len_u + 1);
      end
      if (static_msg) begin
        lane = (k < len_u) ? mem[IW'(k)] : ASC_SPACE;
      end else begin
        lane = (idx == len_u) ? ASC_SPACE : mem[IW'(idx)];
      end
      window[lane_lsb(NUM_DIGITS, k) +: ASC_W] = lane;
    end
  end

  // Registered display window, one cycle behind the state it reflects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= {NUM_DIGITS{ASC_SPACE}};
    end else begin
      digits <= window;
    end
  end

endmodule

// File: tb/tb_asc_scroll_buffer.sv
// Bench for asc_scroll_buffer: directed vector table, hand sequences, randomized run vs. model.
module tb_asc_scroll_buffer;

  localparam int ND  = 4;
  localparam int DP  = 8;
  localparam int TD  = 4;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        scroll_en;
  logic [3:0]  msg_len;
  logic [31:0] digits;

  int n_assert = 0;
  int n_fail   = 0;

  asc_scroll_buffer_if bus ();

  asc_scroll_buffer #(
    .NUM_DIGITS (ND),
    .DEPTH      (DP),
    .TICK_DIV   (TD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .clear     (clear),
    .scroll_en (scroll_en),
    .msg_len   (msg_len),
    .digits    (digits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]      len;
    logic [3:0]      base;
    logic [1:0]      cnt;
    logic [7:0][7:0] mem;
    logic [31:0]     dig;
  } mstate_t;

  mstate_t m;

  // Window = rotation of (message + one space) by base, or left-justified text when it fits.
  function automatic mstate_t model_step(input mstate_t s, input logic v, input logic [7:0] ch,
                                         input logic clr, input logic sen);
    mstate_t n;
    int len, base, p, pos;
    logic [7:0] c;
    logic stp;
    n    = s;
    len  = int'(s.len);
    base = int'(s.base);
    p    = len + 1;
    for (int k = 0; k < ND; k++) begin
      if (len <= ND) begin
        c = (k < len) ? s.mem[k] : 8'h20;
      end else begin
        pos = (base + k) % p;
        c = (pos < len) ? s.mem[pos] : 8'h20;
      end
      n.dig[8*(ND-1-k) +: 8] = c;
    end
    stp = (int'(s.cnt) == TD - 1) && sen;
    if (clr) begin
      n.len = '0; n.base = '0; n.cnt = '0;
    end else begin
      if (sen) n.cnt = 2'((int'(s.cnt) + 1) % TD);
      if (len <= ND) n.base = '0;
      else if (stp) n.base = 4'((base + 1) % (len + 1));
      if (v && len < DP) begin
        n.mem[len] = ch;
        n.len = 4'(len + 1);
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m.len  <= '0;
      m.base <= '0;
      m.cnt  <= '0;
      m.dig  <= {4{8'h20}};
    end else begin
      m <= model_step(m, bus.in_valid, bus.in_char, clear, scroll_en);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] ch, input logic clr, input logic sen);
    bus.in_valid = v;
    bus.in_char  = ch;
    clear        = clr;
    scroll_en    = sen;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  ch;
    logic        clr;
    logic        sen;
    int          reps;
    logic [3:0]  len;
    logic        rdy;
    logic [31:0] dig;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic v, input logic [7:0] ch, input logic clr, input logic sen,
                              input int reps, input logic [3:0] len, input logic rdy,
                              input logic [31:0] dig);
    tbl.push_back('{v, ch, clr, sen, reps, len, rdy, dig});
  endfunction

  logic [7:0] s6 [5];

  initial begin
    // "HELLO" written with scrolling held, then scrolled (steps every 4 clks)
    add(1, "H", 0, 0, 1, 1, 1, "    ");
    add(1, "E", 0, 0, 1, 2, 1, "H   ");
    add(1, "L", 0, 0, 1, 3, 1, "HE  ");
    add(1, "L", 0, 0, 1, 4, 1, "HEL ");
    add(1, "O", 0, 0, 1, 5, 1, "HELL");
    add(0, 0,   0, 1, 4, 5, 1, "HELL");
    add(0, 0,   0, 1, 4, 5, 1, "ELLO");
    add(0, 0,   0, 1, 4, 5, 1, "LLO ");
    add(0, 0,   0, 1, 4, 5, 1, "LO H");
    add(0, 0,   0, 1, 4, 5, 1, "O HE");
    add(0, 0,   0, 1, 4, 5, 1, " HEL");
    add(0, 0,   0, 1, 2, 5, 1, "HELL");
    add(0, 0,   0, 0, 3, 5, 1, "HELL");   // frozen mid-count
    add(1, "Z", 1, 0, 1, 0, 0, "HELL");   // clear beats write
    add(0, 0,   0, 0, 2, 0, 1, "    ");
    // short message stays static across many ticks
    add(1, "H", 0, 0, 1, 1, 1, "    ");
    add(1, "I", 0, 0, 1, 2, 1, "H   ");
    add(0, 0,   0, 1, 80, 2, 1, "HI  ");
    add(0, 0,   1, 0, 1, 0, 0, "HI  ");
    add(0, 0,   0, 0, 1, 0, 1, "    ");
    // fill to capacity, overflow attempt, flush
    add(1, "A", 0, 0, 1, 1, 1, "    ");
    add(1, "B", 0, 0, 1, 2, 1, "A   ");
    add(1, "C", 0, 0, 1, 3, 1, "AB  ");
    add(1, "D", 0, 0, 1, 4, 1, "ABC ");
    add(1, "E", 0, 0, 1, 5, 1, "ABCD");
    add(1, "F", 0, 0, 1, 6, 1, "ABCD");
    add(1, "G", 0, 0, 1, 7, 1, "ABCD");
    add(1, "H", 0, 0, 1, 8, 0, "ABCD");
    add(1, "X", 0, 0, 1, 8, 0, "ABCD");
    add(0, 0,   1, 0, 1, 0, 0, "ABCD");
    add(0, 0,   0, 0, 1, 0, 1, "    ");

    s6[0] = "A"; s6[1] = "B"; s6[2] = "C"; s6[3] = "D"; s6[4] = "E";

    // reset state
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset.digits", digits, 32'h20202020);
    chk("reset.msg_len", 32'(msg_len), 0);
    chk("reset.in_ready", 32'(bus.in_ready), 1);
    rst_n = 1'b1;

    // table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        drive(tbl[i].v, tbl[i].ch, tbl[i].clr, tbl[i].sen);
        @(negedge clk);
        chk($sformatf("tbl%0d.%0d.digits", i, r), digits, tbl[i].dig);
        chk($sformatf("tbl%0d.%0d.msg_len", i, r), 32'(msg_len), 32'(tbl[i].len));
        chk($sformatf("tbl%0d.%0d.in_ready", i, r), 32'(bus.in_ready), 32'(tbl[i].rdy));
      end
    end

    // accept coinciding with a scroll step at len=5
    for (int i = 0; i < 5; i++) begin
      drive(1, s6[i], 0, 0);
      @(negedge clk);
    end
    repeat (3) begin
      drive(0, 0, 0, 1);
      @(negedge clk);
    end
    chk("step6.pre.digits", digits, "ABCD");
    chk("step6.pre.msg_len", 32'(msg_len), 5);
    drive(1, "F", 0, 1);
    @(negedge clk);
    chk("step6.edge.msg_len", 32'(msg_len), 6);
    chk("step6.edge.digits", digits, "ABCD");
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("step6.next.digits", digits, "BCDE");
    chk("step6.next.msg_len", 32'(msg_len), 6);

    // randomized run against the model, with an asynchronous reset mid-run
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 2) != 0, 8'($urandom_range(32, 126)),
            $urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0);
      @(negedge clk);
      chk($sformatf("rnd%0d.digits", i), digits, m.dig);
      chk($sformatf("rnd%0d.msg_len", i), 32'(msg_len), 32'(m.len));
      chk($sformatf("rnd%0d.in_ready", i), 32'(bus.in_ready), 32'((m.len < DP) && !clear));
      if (i == 700) begin
        drive(1, "Q", 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.during.digits", digits, 32'h20202020);
        chk("midrst.during.msg_len", 32'(msg_len), 0);
        chk("midrst.during.in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        chk("midrst.held.digits", digits, 32'h20202020);
        chk("midrst.held.msg_len", 32'(msg_len), 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 1);
        @(negedge clk);
        chk("midrst.after.digits", digits, 32'h20202020);
        chk("midrst.after.msg_len", 32'(msg_len), 0);
        chk("midrst.after.in_ready", 32'(bus.in_ready), 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
